vram_turn_arbiter: RTL and testbench

Owns the single-port 640-bit-wide line VRAM and time-multiplexes it between the text/letter writer path (read-modify-write of one line per turn) and the display scanout line fetch. It generates the `vram_turn` strobe that paces the writer path, which sits directly upstream. It also drives the memory port of the external synchronous block RAM (480 lines × 640 bits).

---
 rtl/vram_pkg.sv | 23 ++
 rtl/vram_disp_req_latch.sv | 46 ++++
 rtl/vram_turn_arbiter.sv | 172 +++++++++++++++++
 tb/tb_vram_turn_arbiter.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/vram_pkg.sv
// Shared definitions for the line-VRAM turn arbiter: geometry constants,
// FSM state encoding and an address range helper.
package vram_pkg;

  localparam int VRAM_LINE_W = 640;
  localparam int VRAM_LINES  = 480;
  localparam int VRAM_ADDR_W = 9;

  typedef enum logic [2:0] {
    S_WADDR  = 3'd0,
    S_WDATA  = 3'd1,
    S_WAIT   = 3'd2,
    S_COMMIT = 3'd3,
    S_DREAD  = 3'd4,
    S_DDATA  = 3'd5
  } vram_state_e;

  function automatic logic vram_addr_ok(input logic [VRAM_ADDR_W-1:0] addr,
                                        input int unsigned lines);
    return (32'(addr) < lines);
  endfunction

endpackage

// File: rtl/vram_disp_req_latch.sv
// Holds one pending scanout fetch request and its line address.
// A newer request overwrites the address; a request in the clearing cycle stays pending.
module vram_disp_req_latch
  import vram_pkg::*;
#(
  parameter int ADDR_W = VRAM_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic [ADDR_W-1:0] addr,
  input  logic              clr,
  output logic              pend,
  output logic [ADDR_W-1:0] pend_addr
);

  logic              pend_q, pend_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  always_comb begin
    pend_d = pend_q;
    addr_d = addr_q;
    if (clr) begin
      pend_d = 1'b0;
    end
    // set wins over clear: the fetch in flight already used the old address
    if (req) begin
      pend_d = 1'b1;
      addr_d = addr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q <= 1'b0;
      addr_q <= '0;
    end else begin
      pend_q <= pend_d;
      addr_q <= addr_d;
    end
  end

  assign pend      = pend_q;
  assign pend_addr = addr_q;

endmodule

// File: rtl/vram_turn_arbiter.sv
// Time-multiplexes the single-port line VRAM between the writer RMW turn and scanout fetches.
// Optional VRAM_ADDR_GUARD_EN: out-of-range lines read as zero, never write, and set addr_err.
//
// state    | meaning
// S_WADDR  | present writer address to RAM, latch it
// S_WDATA  | RAM data returns; load rd_line, pulse vram_turn
// S_WAIT   | writer settle window (WR_SETTLE cycles)
// S_COMMIT | write wr_line back if wr_en
// S_DREAD  | present scanout address, clear pending request
// S_DDATA  | RAM data returns; load disp_line, pulse disp_valid
module vram_turn_arbiter
  import vram_pkg::*;
#(
  parameter int LINE_W    = VRAM_LINE_W,
  parameter int LINES     = VRAM_LINES,
  parameter int WR_SETTLE = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [VRAM_ADDR_W-1:0] wr_addr,
  input  logic [LINE_W-1:0]      wr_line,
  input  logic                   wr_en,
  output logic [LINE_W-1:0]      rd_line,
  output logic                   vram_turn,
  input  logic                   disp_req,
  input  logic [VRAM_ADDR_W-1:0] disp_addr,
  output logic [LINE_W-1:0]      disp_line,
  output logic                   disp_valid,
  output logic [VRAM_ADDR_W-1:0] mem_addr,
  output logic                   mem_we,
  output logic [LINE_W-1:0]      mem_wdata,
  input  logic [LINE_W-1:0]      mem_rdata,
  output logic                   addr_err
);

`ifdef VRAM_ADDR_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  localparam int CNT_W = (WR_SETTLE > 1) ? $clog2(WR_SETTLE) : 1;

  vram_state_e            state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [VRAM_ADDR_W-1:0] addr_q, addr_d;
  logic [LINE_W-1:0]      rd_line_q, rd_line_d;
  logic                   vram_turn_q, vram_turn_d;
  logic [LINE_W-1:0]      disp_line_q, disp_line_d;
  logic                   disp_valid_q, disp_valid_d;
  logic                   dbad_q, dbad_d;
  logic                   addr_err_q, addr_err_d;

  logic                   disp_pend;
  logic [VRAM_ADDR_W-1:0] daddr;
  logic                   wr_bad, dr_bad;

  vram_disp_req_latch #(
    .ADDR_W (VRAM_ADDR_W)
  ) u_disp_req_latch (
    .clk       (clk),
    .rst       (rst),
    .req       (disp_req),
    .addr      (disp_addr),
    .clr       (state_q == S_DREAD),
    .pend      (disp_pend),
    .pend_addr (daddr)
  );

  assign wr_bad = GUARD && !vram_addr_ok(addr_q, LINES);
  assign dr_bad = GUARD && !vram_addr_ok(daddr, LINES);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    rd_line_d    = rd_line_q;
    vram_turn_d  = 1'b0;
    disp_line_d  = disp_line_q;
    disp_valid_d = 1'b0;
    dbad_d       = dbad_q;
    addr_err_d   = addr_err_q;
    case (state_q)
      S_WADDR: begin
        addr_d  = wr_addr;
        state_d = S_WDATA;
      end
      S_WDATA: begin
        rd_line_d   = wr_bad ? '0 : mem_rdata;
        vram_turn_d = 1'b1;
        addr_err_d  = addr_err_q | wr_bad;
        cnt_d       = CNT_W'(WR_SETTLE - 1);
        state_d     = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          state_d = S_COMMIT;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_COMMIT: begin
        // a request arriving in this very cycle is serviced right away
        state_d = (disp_pend || disp_req) ? S_DREAD : S_WADDR;
      end
      S_DREAD: begin
        // remember range status now; the latch may be overwritten before data returns
        dbad_d  = dr_bad;
        state_d = S_DDATA;
      end
      S_DDATA: begin
        disp_line_d  = dbad_q ? '0 : mem_rdata;
        disp_valid_d = 1'b1;
        addr_err_d   = addr_err_q | dbad_q;
        state_d      = S_WADDR;
      end
      default: state_d = S_WADDR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_WADDR;
      cnt_q        <= '0;
      addr_q       <= '0;
      rd_line_q    <= '0;
      vram_turn_q  <= 1'b0;
      disp_line_q  <= '0;
      disp_valid_q <= 1'b0;
      dbad_q       <= 1'b0;
      addr_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      rd_line_q    <= rd_line_d;
      vram_turn_q  <= vram_turn_d;
      disp_line_q  <= disp_line_d;
      disp_valid_q <= disp_valid_d;
      dbad_q       <= dbad_d;
      addr_err_q   <= addr_err_d;
    end
  end

  // RAM port is decoded from state; gating with rst kills a commit in the reset cycle
  always_comb begin
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    if (!rst) begin
      case (state_q)
        S_WADDR: mem_addr = wr_addr;
        S_COMMIT: begin
          mem_addr = addr_q;
          if (wr_en && !wr_bad) begin
            mem_we    = 1'b1;
            mem_wdata = wr_line;
          end
        end
        S_DREAD: mem_addr = daddr;
        default: mem_addr = '0;
      endcase
    end
  end

  assign rd_line    = rd_line_q;
  assign vram_turn  = vram_turn_q;
  assign disp_line  = disp_line_q;
  assign disp_valid = disp_valid_q;
  assign addr_err   = addr_err_q;

endmodule

// File: tb/tb_vram_turn_arbiter.sv
// Bench for vram_turn_arbiter: behavioural RAM plus a line-level shadow model,
// directed rounds followed by randomized rounds.
module tb_vram_turn_arbiter;

  localparam int LW = 640;
  localparam int NL = 480;
  localparam int W  = 2;
  localparam int RL = 3 + W;
  localparam int CM = 2 + W;

`ifdef VRAM_ADDR_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic          clk, rst;
  logic [8:0]    wr_addr, disp_addr, mem_addr;
  logic [LW-1:0] wr_line, rd_line, disp_line, mem_wdata, mem_rdata;
  logic          wr_en, vram_turn, disp_req, disp_valid, mem_we, addr_err;

  vram_turn_arbiter #(.LINE_W(LW), .LINES(NL), .WR_SETTLE(W)) dut (
    .clk(clk), .rst(rst), .wr_addr(wr_addr), .wr_line(wr_line), .wr_en(wr_en),
    .rd_line(rd_line), .vram_turn(vram_turn), .disp_req(disp_req),
    .disp_addr(disp_addr), .disp_line(disp_line), .disp_valid(disp_valid),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .addr_err(addr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [LW-1:0] ram [512];
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  // shadow model: what each line should hold, plus pending display/expected outputs
  logic [LW-1:0] model [512];
  bit            pend, dv_due, dv_bad, exp_err;
  logic [8:0]    pend_addr;
  logic [LW-1:0] dv_line, exp_rd, exp_dl;
  int            checks, errors;

  function automatic logic [LW-1:0] rnd_line();
    logic [LW-1:0] r;
    for (int i = 0; i < LW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [8:0] rnd_addr();
    if (GUARD && $urandom_range(7) == 0) return 9'($urandom_range(511, NL));
    return 9'($urandom_range(NL - 1));
  endfunction

  function automatic logic [LW-1:0] line_of(input logic [8:0] a);
    if (GUARD && a >= 9'(NL)) return '0;
    return model[a];
  endfunction

  task automatic check_b(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_a(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_l(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic hold_checks(input string tag);
    check_b({tag, "_turn"}, vram_turn, 1'b0);
    check_b({tag, "_dvalid"}, disp_valid, 1'b0);
    check_b({tag, "_we"}, mem_we, 1'b0);
    check_l({tag, "_rd_line"}, rd_line, exp_rd);
    check_l({tag, "_disp_line"}, disp_line, exp_dl);
    check_b({tag, "_addr_err"}, addr_err, exp_err);
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  // One writer round starting in the current (S_WADDR) cycle. req_mask bit c raises
  // disp_req at round offset c; da >= 0 fixes the requested line, else random.
  task automatic round(input logic [8:0] a, input bit en, input logic [LW-1:0] d,
                       input logic [4:0] req_mask, input int da, input bit rst_cm);
    bit         wr_ok;
    logic [8:0] fa;
    wr_ok = en && !(GUARD && a >= 9'(NL)) && !rst_cm;
    for (int c = 0; c < RL; c++) begin
      wr_addr  = (c == 0) ? a : rnd_addr();
      wr_en    = (c == CM) ? en : 1'($urandom);
      wr_line  = (c == CM) ? d : rnd_line();
      disp_req = req_mask[c];
      disp_addr = (req_mask[c] && da >= 0) ? 9'(da) : rnd_addr();
      if (disp_req) begin
        pend = 1'b1;
        pend_addr = disp_addr;
      end
      if (c == CM && rst_cm) rst = 1'b1;
      #1;
      if (c == 0 && dv_due) begin
        exp_dl = dv_line;
        if (dv_bad) exp_err = 1'b1;
      end
      if (c == 2) begin
        exp_rd = line_of(a);
        if (GUARD && a >= 9'(NL)) exp_err = 1'b1;
      end
      check_b("vram_turn", vram_turn, c == 2);
      check_b("disp_valid", disp_valid, c == 0 && dv_due);
      check_l("rd_line", rd_line, exp_rd);
      check_l("disp_line", disp_line, exp_dl);
      check_b("addr_err", addr_err, exp_err);
      check_b("mem_we", mem_we, c == CM && wr_ok);
      if (c == 0) check_a("mem_addr_waddr", mem_addr, a);
      if (c == CM && wr_ok) begin
        check_a("mem_addr_commit", mem_addr, a);
        check_l("mem_wdata", mem_wdata, d);
        model[a] = d;
      end
      if (c == 0) dv_due = 1'b0;
      advance();
    end
    disp_req = 1'b0;
    if (rst_cm) begin
      // reset was sampled: everything returns to zero, pending fetch dropped
      exp_rd = '0; exp_dl = '0; exp_err = 1'b0; pend = 1'b0; dv_due = 1'b0;
      #1;
      hold_checks("rst_commit");
      check_a("rst_mem_addr", mem_addr, 9'd0);
      check_l("rst_mem_wdata", mem_wdata, '0);
      rst = 1'b0;
      return;
    end
    if (pend) begin
      fa = pend_addr;
      pend = 1'b0;
      wr_en = 1'b1; wr_line = rnd_line(); wr_addr = rnd_addr();
      #1;
      hold_checks("dread");
      check_a("dread_mem_addr", mem_addr, fa);
      advance();
      #1;
      hold_checks("ddata");
      dv_due = 1'b1;
      dv_line = line_of(fa);
      dv_bad = GUARD && fa >= 9'(NL);
      advance();
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    pend = 1'b0; dv_due = 1'b0; dv_bad = 1'b0; exp_err = 1'b0;
    pend_addr = '0; dv_line = '0;
    rst = 1'b1; wr_addr = 9'd123; wr_line = '1; wr_en = 1'b1;
    disp_req = 1'b1; disp_addr = 9'd5;
    for (int i = 0; i < 512; i++) begin
      ram[i] = rnd_line();
      model[i] = ram[i];
    end
    ram[100] = {80{8'hAA}};
    model[100] = {80{8'hAA}};

    advance();
    advance();
    exp_rd = '0; exp_dl = '0;
    hold_checks("reset");
    check_a("reset_mem_addr", mem_addr, 9'd0);
    check_l("reset_mem_wdata", mem_wdata, '0);
    disp_req = 1'b0;
    rst = 1'b0;

    round(9'd100, 1'b1, {80{8'h55}}, 5'b00100, 100, 1'b0);
    round(9'd200, 1'b0, rnd_line(), 5'b00000, -1, 1'b0);
    round(9'd7, 1'b1, rnd_line(), 5'b10000, 7, 1'b0);
    round(9'd300, 1'b1, rnd_line(), 5'b00011, -1, 1'b0);
    round(9'd301, 1'b1, rnd_line(), 5'b00000, -1, 1'b0);
`ifdef VRAM_ADDR_GUARD_EN
    round(9'd480, 1'b1, rnd_line(), 5'b00000, -1, 1'b0);
    round(9'd10, 1'b1, rnd_line(), 5'b00010, 500, 1'b0);
    round(9'd11, 1'b1, rnd_line(), 5'b00000, -1, 1'b0);
`endif
    round(9'd50, 1'b1, rnd_line(), 5'b00001, -1, 1'b1);
    round(9'd50, 1'b0, rnd_line(), 5'b00000, -1, 1'b0);

    for (int i = 0; i < 40; i++) begin
      logic [8:0] a;
      bit         en;
      logic [4:0] m;
      a  = rnd_addr();
      en = 1'($urandom_range(1));
      m  = ($urandom_range(2) == 0) ? 5'($urandom) : 5'b00000;
      round(a, en, rnd_line(), m, -1, 1'b0);
    end
    round(9'd1, 1'b0, rnd_line(), 5'b00000, -1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
